// File: rtl/canal_eventos.sv
// Multi-channel input capture: synchronise, detect edges, queue them as event records drained round-robin.
// Optional glitch filter stage enabled by defining CANAL_EVENTOS_GLITCH_FILTER_EN.
module canal_eventos #(
  parameter int N_CH        = 21,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  in_ch,
  output logic [N_CH-1:0]  lvl_out,
  output logic [N_CH-1:0]  rise_out,
  output logic [N_CH-1:0]  fall_out,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [CH_W-1:0]  ev_chan,
  output logic             ev_type,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             overflow
);

  typedef enum logic {IDLE, PRESENT} state_t;

  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
  logic [N_CH-1:0]  sync_s;
  logic [N_CH-1:0]  lvl_q, lvl_d;
  logic [N_CH-1:0]  rise_q, rise_d;
  logic [N_CH-1:0]  fall_q, fall_d;
  logic [N_CH-1:0]  pr_q, pr_d, pf_q, pf_d;
  logic [N_CH-1:0]  clr_r, clr_f, drop_r, drop_f;
  logic [N_CH-1:0]  req, gnt_oh;
  logic             found, gnt_r, gnt_f, any_drop;
  logic [CH_W-1:0]  gnt_idx, gnt_next;
  logic [CH_W-1:0]  rr_q, rr_d;
  state_t           state_q, state_d;
  logic             ev_valid_q, ev_valid_d;
  logic [CH_W-1:0]  ev_chan_q, ev_chan_d;
  logic             ev_type_q, ev_type_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             overflow_q, overflow_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], in_ch};
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef CANAL_EVENTOS_GLITCH_FILTER_EN
  logic [N_CH-1:0] filt_q;
  logic [N_CH-1:0] stable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) filt_q <= '0;
    else       filt_q <= sync_s;
  end

  // A new level is taken only once it has been seen on two consecutive cycles.
  assign stable = ~(sync_s ^ filt_q);
  assign lvl_d  = (stable & sync_s) | (~stable & lvl_q);
`else
  assign lvl_d = sync_s;
`endif

  assign rise_d = lvl_d & ~lvl_q;
  assign fall_d = ~lvl_d & lvl_q;

  // Round-robin search: first request at/after rr_q, else wrap to the lowest request.
  always_comb begin : arb
    int  hi_idx, lo_idx, sel;
    logic found_hi;
    req      = pr_q | pf_q;
    found_hi = 1'b0;
    found    = 1'b0;
    hi_idx   = 0;
    lo_idx   = 0;
    for (int i = 0; i < N_CH; i++) begin
      if (req[i]) begin
        if (!found_hi && (i >= int'(rr_q))) begin
          found_hi = 1'b1;
          hi_idx   = i;
        end
        if (!found) begin
          found  = 1'b1;
          lo_idx = i;
        end
      end
    end
    sel    = found_hi ? hi_idx : lo_idx;
    gnt_oh = '0;
    for (int i = 0; i < N_CH; i++) gnt_oh[i] = found && (i == sel);
    gnt_r    = |(pr_q & gnt_oh);
    gnt_f    = |(pf_q & gnt_oh);
    gnt_idx  = CH_W'(sel);
    gnt_next = (sel == N_CH - 1) ? '0 : CH_W'(sel + 1);
  end

  always_comb begin
    state_d    = state_q;
    ev_valid_d = ev_valid_q;
    ev_chan_d  = ev_chan_q;
    ev_type_d  = ev_type_q;
    rr_d       = rr_q;
    clr_r      = '0;
    clr_f      = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          ev_valid_d = 1'b1;
          ev_chan_d  = gnt_idx;
          state_d    = PRESENT;
          if (gnt_r) begin
            ev_type_d = 1'b1;
            clr_r     = gnt_oh;
            // Hold the pointer so the pending fall on this channel is next.
            rr_d      = gnt_f ? gnt_idx : gnt_next;
          end else begin
            ev_type_d = 1'b0;
            clr_f     = gnt_oh;
            rr_d      = gnt_next;
          end
        end
      end
      PRESENT: begin
        if (ev_ready) begin
          ev_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pr_d     = (pr_q & ~clr_r) | rise_d;
  assign pf_d     = (pf_q & ~clr_f) | fall_d;
  assign drop_r   = rise_d & pr_q & ~clr_r;
  assign drop_f   = fall_d & pf_q & ~clr_f;
  assign any_drop = |(drop_r | drop_f);

  assign drop_cnt_d = (any_drop && (drop_cnt_q != {CNT_W{1'b1}})) ? drop_cnt_q + CNT_W'(1) : drop_cnt_q;
  assign overflow_d = overflow_q | any_drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl_q      <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      pr_q       <= '0;
      pf_q       <= '0;
      rr_q       <= '0;
      state_q    <= IDLE;
      ev_valid_q <= 1'b0;
      ev_chan_q  <= '0;
      ev_type_q  <= 1'b0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      lvl_q      <= lvl_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      pr_q       <= pr_d;
      pf_q       <= pf_d;
      rr_q       <= rr_d;
      state_q    <= state_d;
      ev_valid_q <= ev_valid_d;
      ev_chan_q  <= ev_chan_d;
      ev_type_q  <= ev_type_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign lvl_out  = lvl_q;
  assign rise_out = rise_q;
  assign fall_out = fall_q;
  assign ev_valid = ev_valid_q;
  assign ev_chan  = ev_chan_q;
  assign ev_type  = ev_type_q;
  assign drop_cnt = drop_cnt_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_canal_eventos.sv
// Scoreboard bench for canal_eventos: expected event records are queued at stimulus time
// and compared whenever the DUT presents a record.
module tb_canal_eventos;
  localparam int N_CH = 21;
  localparam int SS   = 2;
`ifdef CANAL_EVENTOS_GLITCH_FILTER_EN
  localparam int PL = SS + 2;
`else
  localparam int PL = SS + 1;
`endif

  typedef struct packed {
    logic [4:0] chan;
    logic       typ;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, ev_ready, ev_valid, ev_type, overflow;
  logic [N_CH-1:0] in_ch, lvl_out, rise_out, fall_out;
  logic [4:0]      ev_chan;
  logic [7:0]      drop_cnt;

  logic       reset2, ready2, valid2, type2, ovf2;
  logic [3:0] in2, lvl2, rise2, fall2;
  logic [1:0] chan2, drop2;

  canal_eventos #(.N_CH(N_CH), .SYNC_STAGES(SS), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .in_ch(in_ch), .lvl_out(lvl_out), .rise_out(rise_out),
    .fall_out(fall_out), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_chan(ev_chan),
    .ev_type(ev_type), .drop_cnt(drop_cnt), .overflow(overflow)
  );

  canal_eventos #(.N_CH(4), .SYNC_STAGES(SS), .CNT_W(2)) u_dut_sat (
    .clk(clk), .reset(reset2), .in_ch(in2), .lvl_out(lvl2), .rise_out(rise2),
    .fall_out(fall2), .ev_valid(valid2), .ev_ready(ready2), .ev_chan(chan2),
    .ev_type(type2), .drop_cnt(drop2), .overflow(ovf2)
  );

  int  n_checks = 0;
  int  n_fail   = 0;
  ev_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_ev(input int c, input logic t);
    ev_t e;
    e.chan = 5'(c);
    e.typ  = t;
    exp_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    in_ch = '0;
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(2);
  endtask

  // Every presented record must match the scoreboard head; popped on handshake.
  always @(negedge clk) begin
    if (!reset && ev_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {ev_chan, ev_type}, 0);
      end else begin
        check("ev_chan", ev_chan, exp_q[0].chan);
        check("ev_type", ev_type, exp_q[0].typ);
        if (ev_ready) begin
          $display("event accepted: chan=%0d type=%0d", ev_chan, ev_type);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic seen;
    reset = 1'b1; in_ch = '0; ev_ready = 1'b1;
    reset2 = 1'b1; in2 = '0; ready2 = 1'b1;

    @(negedge clk);
    check("rst_lvl", lvl_out, 0);
    check("rst_rise", rise_out, 0);
    check("rst_fall", fall_out, 0);
    check("rst_valid", ev_valid, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_ovf", overflow, 0);
    check("rst_chan", ev_chan, 0);
    cycles(2);
    reset = 1'b0; reset2 = 1'b0;

    // Quiet inputs: nothing moves
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | ev_valid | (|lvl_out) | (|rise_out) | (|fall_out) | overflow | (|drop_cnt);
    end
    check("idle_quiet", seen, 0);

    // Single rise on channel 5: exact latency and one-cycle pulse
    @(posedge clk); #1;
    in_ch[5] = 1'b1;
    push_ev(5, 1'b1);
    wait_neg(PL - 1);
    check("lvl5_early", lvl_out[5], 0);
    @(negedge clk);
    check("lvl5", lvl_out, 21'h20);
    check("rise5", rise_out, 21'h20);
    check("valid_not_yet", ev_valid, 0);
    @(negedge clk);
    check("rise5_end", rise_out, 0);
    check("valid5", ev_valid, 1);
    @(negedge clk);
    check("valid5_low", ev_valid, 0);
    check("q_empty_single", exp_q.size(), 0);

    // Simultaneous rises under backpressure drain in round-robin order
    do_reset();
    ev_ready = 1'b0;
    in_ch[3] = 1'b1; in_ch[7] = 1'b1; in_ch[20] = 1'b1;
    push_ev(3, 1'b1); push_ev(7, 1'b1); push_ev(20, 1'b1);
    cycles(12);
    check("held_valid", ev_valid, 1);
    check("lvl_multi", lvl_out, 21'h100088);
    ev_ready = 1'b1;
    cycles(12);
    check("q_empty_multi", exp_q.size(), 0);

    // Drop: output busy with ch9, then ch2 rise, fall, rise -> second rise lost
    do_reset();
    ev_ready = 1'b0;
    in_ch[9] = 1'b1;
    push_ev(9, 1'b1);
    cycles(6);
    in_ch[2] = 1'b1;
    push_ev(2, 1'b1);
    cycles(4);
    in_ch[2] = 1'b0;
    push_ev(2, 1'b0);
    cycles(6);
    check("no_drop_yet", drop_cnt, 0);
    check("no_ovf_yet", overflow, 0);
    in_ch[2] = 1'b1;
    cycles(6);
    check("drop_one", drop_cnt, 1);
    check("ovf_set", overflow, 1);
    ev_ready = 1'b1;
    cycles(14);
    check("q_empty_drop", exp_q.size(), 0);
    check("ovf_sticky", overflow, 1);
    check("drop_hold", drop_cnt, 1);

    // Saturating counter on the CNT_W=2 instance
    ready2 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      in2[0] = ~in2[0];
      cycles(4);
      if (i == 5) check("sat_cnt_mid", drop2, 2);
    end
    cycles(2);
    check("sat_cnt", drop2, 3);
    check("sat_ovf", ovf2, 1);
    check("sat_valid", valid2, 1);
    check("sat_rec", {chan2, type2}, 3'b001);
    @(negedge clk); #2;
    reset2 = 1'b1;
    #1;
    check("async_valid", valid2, 0);
    check("async_drop", drop2, 0);
    check("async_ovf", ovf2, 0);
    cycles(2);
    reset2 = 1'b0;

`ifdef CANAL_EVENTOS_GLITCH_FILTER_EN
    do_reset();
    ev_ready = 1'b1;
    in_ch[0] = 1'b1;
    cycles(1);
    in_ch[0] = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | rise_out[0] | ev_valid;
    end
    check("glitch_suppressed", seen, 0);
    @(posedge clk); #1;
    in_ch[0] = 1'b1;
    push_ev(0, 1'b1);
    wait_neg(PL - 1);
    check("filt_rise_early", rise_out[0], 0);
    @(negedge clk);
    check("filt_rise", rise_out[0], 1);
    @(posedge clk); #1;
    in_ch[0] = 1'b0;
    push_ev(0, 1'b0);
    cycles(12);
`endif

    cycles(4);
    check("q_final", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
